// File: rtl/convolve_fpga_mac_pipe.sv
// convolve_fpga_mac_pipe: 4-stage signed MAC pipeline. It produces one narrowed sum per TAPS accepted pairs.
// Define CONVOLVE_FPGA_MAC_SAT_EN to saturate on narrowing. Without it, narrowing wraps.
module convolve_fpga_mac_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 8,
  parameter int B_SIGNED  = 0,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int TAPS      = 9,
  parameter int SHIFT     = 0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 busy
);
  localparam int PW    = A_WIDTH + B_WIDTH + 1;
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

  logic                        w_adv;
  logic                        w_accept;
  logic                        w_first;
  logic                        w_last;
  logic signed [B_WIDTH:0]     w_b_ext;
  logic signed [PW-1:0]        w_prod;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_shift;
  logic [OUT_WIDTH-1:0]        w_narrow;

  logic [CNT_W-1:0]            r_cnt;
  logic                        r_s1_valid, r_s1_first, r_s1_last;
  logic signed [A_WIDTH-1:0]   r_s1_a;
  logic signed [B_WIDTH:0]     r_s1_b;
  logic                        r_s2_valid, r_s2_first, r_s2_last;
  logic signed [PW-1:0]        r_s2_prod;
  logic                        r_s3_valid, r_s3_last;
  logic signed [ACC_WIDTH-1:0] r_acc;

  // The whole pipe freezes only while a finished result waits for the consumer.
  assign w_adv    = !(out_valid && !out_ready);
  assign in_ready = w_adv;
  assign w_accept = in_valid && w_adv;
  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == LAST_CNT);

  assign w_b_ext    = (B_SIGNED != 0) ? $signed({din1[B_WIDTH-1], din1}) : $signed({1'b0, din1});
  assign w_prod     = PW'(r_s1_a) * PW'(r_s1_b);
  assign w_prod_ext = ACC_WIDTH'(r_s2_prod);
  assign w_shift    = r_acc >>> SHIFT;

  always_comb begin
    w_narrow = OUT_WIDTH'(w_shift);
`ifdef CONVOLVE_FPGA_MAC_SAT_EN
    // The value fits only when the bits above the output sign bit all repeat that sign bit.
    if (!((&w_shift[ACC_WIDTH-1:OUT_WIDTH-1]) || !(|w_shift[ACC_WIDTH-1:OUT_WIDTH-1]))) begin
      w_narrow = w_shift[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
`else
    w_narrow = OUT_WIDTH'(w_shift);
`endif
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_prod  <= '0;
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
      r_acc      <= '0;
      out_valid  <= 1'b0;
      dout       <= '0;
    end else if (w_adv) begin
      if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end

      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        r_s1_a     <= $signed(din0);
        r_s1_b     <= w_b_ext;
      end

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_prod  <= w_prod;
      end

      // A first-tagged product restarts the sum, so windows can follow each other with no clear cycle.
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_last <= r_s2_last;
        r_acc     <= r_s2_first ? w_prod_ext : r_acc + w_prod_ext;
      end

      if (r_s3_valid && r_s3_last) begin
        out_valid <= 1'b1;
        dout      <= w_narrow;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = r_s1_valid || r_s2_valid || r_s3_valid || out_valid || (r_cnt != '0);

endmodule

// File: tb/tb_convolve_fpga_mac_pipe.sv
// Testbench for convolve_fpga_mac_pipe. The stimulus side pushes expected window results into a queue.
// A separate monitor pops one entry and compares it each time the DUT hands over a result.
module tb_convolve_fpga_mac_pipe;
  localparam int TAPS     = 9;
  localparam int SHIFT    = 0;
  localparam int B_SIGNED = 0;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din0;
  logic [7:0]  din1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        busy;

  convolve_fpga_mac_pipe #(
    .A_WIDTH(16), .B_WIDTH(8), .B_SIGNED(B_SIGNED), .ACC_WIDTH(32),
    .OUT_WIDTH(16), .TAPS(TAPS), .SHIFT(SHIFT)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  longint      win_sum = 0;
  int          ntap = 0;
  int          pops = 0;
  logic [15:0] last_dout = '0;
  int          rdy_pct = 100;
  int          bubble_pct = 0;
  int          stall_cnt = 0;
  bit          stall_arm = 0;
  bit          held = 0;
  logic [15:0] held_val = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=progress", nm);
  endtask

  // Reference: exact window sum, wrapped to 32 bits, arithmetic shift, then narrowed to 16 bits.
  function automatic logic [15:0] model_result(input longint sum);
    logic signed [31:0] acc;
    logic signed [31:0] sh;
    acc = sum[31:0];
    sh  = acc >>> SHIFT;
`ifdef CONVOLVE_FPGA_MAC_SAT_EN
    if (sh > 32767)  return 16'h7FFF;
    if (sh < -32768) return 16'h8000;
`endif
    return sh[15:0];
  endfunction

  task automatic model_accept(input logic [15:0] a, input logic [7:0] b);
    longint av;
    longint bv;
    av = longint'($signed(a));
    bv = (B_SIGNED != 0) ? longint'($signed(b)) : longint'(b);
    win_sum += av * bv;
    ntap++;
    if (ntap == TAPS) begin
      exp_q.push_back(model_result(win_sum));
      win_sum = 0;
      ntap = 0;
    end
  endtask

  task automatic drive_ready();
    if (stall_arm && out_valid) begin
      stall_cnt = 5;
      stall_arm = 0;
    end
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else begin
      out_ready = ($urandom_range(99) < rdy_pct);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] b);
    int guard;
    guard = 0;
    forever begin
      @(negedge ap_clk);
      drive_ready();
      if ($urandom_range(99) < bubble_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        din0 = a;
        din1 = b;
        #1;
        if (in_ready) begin
          model_accept(a, b);
          return;
        end
      end
      guard++;
      if (guard > 500) begin
        fail_now("send_timeout");
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge ap_clk);
      drive_ready();
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    bit done;
    guard = 0;
    done = 0;
    rdy_pct = 100;
    while (!done && guard < 300) begin
      @(negedge ap_clk);
      drive_ready();
      in_valid = 1'b0;
      #1;
      if (exp_q.size() == 0 && !busy) done = 1;
      guard++;
    end
    if (!done) fail_now("drain_timeout");
    chk("drain_busy", busy, 0);
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic window(input logic [15:0] a, input logic [7:0] b);
    for (int i = 0; i < TAPS; i++) send(a, b);
  endtask

  // Monitor: compares every handed-over result and checks that a stalled dout does not move.
  always @(negedge ap_clk) begin
    #2;
    if (!ap_rst_n) begin
      held = 0;
    end else begin
      if (held) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_dout_stable", dout, held_val);
        held = 0;
      end
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("result", $signed(dout), $signed(exp_q.pop_front()));
        end
        last_dout = dout;
        pops++;
      end else if (out_valid) begin
        held = 1;
        held_val = dout;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    ap_rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    din0 = '0;
    din1 = '0;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_dout", dout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);
    idle(2);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // 9 x (100*2): the result must rise exactly three edges after the last accept.
    p0 = pops;
    window(16'd100, 8'd2);
    for (int k = 1; k <= 4; k++) begin
      @(negedge ap_clk);
      drive_ready();
      in_valid = 1'b0;
      #1;
      chk($sformatf("latency_after_edge_%0d", k - 1), out_valid, (k == 4));
    end
    drain();
    chk("basic_1800", $signed(last_dout), 1800);
    chk("basic_one_pulse", pops - p0, 1);

    window(16'hFF9C, 8'd2);
    drain();
    chk("negative_m1800", $signed(last_dout), -1800);

    window(16'd1000, 8'd200);
    drain();
`ifdef CONVOLVE_FPGA_MAC_SAT_EN
    chk("narrow_sat", $signed(last_dout), 32767);
`else
    chk("narrow_wrap", $signed(last_dout), 30528);
`endif

    // Two back-to-back windows. The consumer stalls for 5 cycles when the first result appears.
    p0 = pops;
    stall_arm = 1;
    window(16'd100, 8'd2);
    window(16'd100, 8'd2);
    drain();
    chk("stall_two_results", pops - p0, 2);
    chk("stall_second_1800", $signed(last_dout), 1800);
    chk("stall_was_applied", stall_arm, 0);

    // Reset after 4 taps. The partial sum must be discarded.
    for (int i = 0; i < 4; i++) send(16'd100, 8'd2);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_out_valid", out_valid, 0);
    win_sum = 0;
    ntap = 0;
    exp_q.delete();
    idle(2);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    p0 = pops;
    window(16'd100, 8'd2);
    drain();
    chk("after_reset_one_result", pops - p0, 1);
    chk("after_reset_1800", $signed(last_dout), 1800);

    // Random traffic with input bubbles and output back-pressure.
    p0 = pops;
    for (int w = 0; w < 1000; w++) begin
      rdy_pct = 60 + $urandom_range(40);
      bubble_pct = $urandom_range(30);
      for (int t = 0; t < TAPS; t++) begin
        logic [15:0] a;
        logic [7:0]  b;
        a = 16'($urandom);
        b = 8'($urandom);
        if ($urandom_range(15) == 0) a = ($urandom_range(1) != 0) ? 16'h7FFF : 16'h8000;
        if ($urandom_range(15) == 0) b = 8'hFF;
        send(a, b);
      end
    end
    bubble_pct = 0;
    drain();
    chk("random_result_count", pops - p0, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
